// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Delivers each byte as a one-cycle o_Valid pulse, with parity and framing error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8681,
  parameter int PARITY_EN    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_UART,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BREAK
  } state_t;

  state_t      state, state_next;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic [15:0] timer, timer_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift, shift_next;
  logic        par, par_next;
  logic        stop_bit, stop_bit_next;
  logic [7:0]  data_next;
  logic        valid_next, perr_next, ferr_next;
  logic        bit_end;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], i_UART};
  end

  assign rx_s    = sync_q[1];
  assign bit_end = (timer == BIT_LAST);
  assign o_Busy  = (state != IDLE);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next    = state;
    timer_next    = bit_end ? 16'd0 : timer + 16'd1;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    par_next      = par;
    stop_bit_next = stop_bit;
    data_next     = o_Data;
    valid_next    = 1'b0;
    perr_next     = 1'b0;
    ferr_next     = 1'b0;

    case (state)
      IDLE: begin
        timer_next = 16'd0;
        if (!rx_s) state_next = START;
      end
      // Mid-start-bit recheck rejects short glitches on the idle line.
      START: begin
        if (timer == HALF_LAST) begin
          timer_next = 16'd0;
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
            par_next     = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = {rx_s, shift[7:1]};
          par_next     = par ^ rx_s;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_next   = par ^ rx_s;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          stop_bit_next = rx_s;
          state_next    = DONE;
        end
      end
      DONE: begin
        if (stop_bit) begin
          data_next  = shift;
          valid_next = 1'b1;
          perr_next  = (PARITY_EN != 0) && par;
          state_next = IDLE;
        end else begin
          ferr_next  = 1'b1;
          state_next = BREAK;
        end
      end
      // Wait out a held-low line so a break never looks like a new start bit.
      BREAK: begin
        timer_next = 16'd0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      timer        <= 16'd0;
      bit_idx      <= 3'd0;
      shift        <= 8'd0;
      par          <= 1'b0;
      stop_bit     <= 1'b0;
      o_Data       <= 8'd0;
      o_Valid      <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      timer        <= timer_next;
      bit_idx      <= bit_idx_next;
      shift        <= shift_next;
      par          <= par_next;
      stop_bit     <= stop_bit_next;
      o_Data       <= data_next;
      o_Valid      <= valid_next;
      o_Parity_Err <= perr_next;
      o_Frame_Err  <= ferr_next;
    end
  end

endmodule
